// File: rtl/flash_pkg.sv
// Shared types and defaults for the LED flasher step/mode controller.
package flash_pkg;

  typedef enum logic [1:0] {
    MODE_SCAN  = 2'b00,
    MODE_TRACK = 2'b01,
    MODE_BLINK = 2'b10
  } mode_t;

  typedef enum logic {
    ST_SEEK = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int unsigned DEF_INT_PERIOD    = 4750000;
  localparam int unsigned DEF_WD_LIMIT      = 50000000;
  localparam int unsigned DEF_RECOVER_EDGES = 4;

  // SCAN when all switches are off, TRACK for exactly one switch, BLINK otherwise.
  function automatic mode_t decode_mode(input logic [7:0] ctrl);
    if (ctrl == 8'd0)
      return MODE_SCAN;
    else if ((ctrl & (ctrl - 8'd1)) == 8'd0)
      return MODE_TRACK;
    else
      return MODE_BLINK;
  endfunction

endpackage

// File: rtl/ext_tick_sync.sv
// Brings the asynchronous 555 output into the clk domain and flags its rising edges.
module ext_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_timer,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_timer;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/flash_tick_scheduler.sv
// Step source selection (555 vs internal divider), 555 watchdog/lock FSM and mode/restart control.
module flash_tick_scheduler
  import flash_pkg::*;
#(
  parameter int unsigned INT_PERIOD    = DEF_INT_PERIOD,
  parameter int unsigned WD_LIMIT      = DEF_WD_LIMIT,
  parameter int unsigned RECOVER_EDGES = DEF_RECOVER_EDGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_timer,
  input  logic [7:0] control,
  output logic       step_en,
  output logic [1:0] mode,
  output logic       restart,
  output logic       src_ext,
  output logic       timer_lost
);

  localparam int unsigned CNT_W = $clog2(INT_PERIOD);
  localparam int unsigned WD_W  = $clog2(WD_LIMIT + 1);
  localparam int unsigned EC_W  = $clog2(RECOVER_EDGES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INT_PERIOD - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(WD_LIMIT);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WD_LIMIT - 1);
  localparam logic [EC_W-1:0]  EC_TARGET = EC_W'(RECOVER_EDGES);

  logic             w_ext_edge;
  mode_t            r_mode_q;
  mode_t            w_mode_d;
  logic             w_restart_d;
  logic             r_restart;
  logic             r_step;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [EC_W-1:0]  r_ecnt;
  logic [EC_W-1:0]  w_ecnt_d;
  state_t           r_state;
  state_t           w_state_d;
  logic             w_int_tick;
  logic             w_expire;
  logic             w_src_ext;

  ext_tick_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_timer (i_timer),
    .o_edge  (w_ext_edge)
  );

  assign w_mode_d    = decode_mode(control);
  assign w_restart_d = (w_mode_d != r_mode_q);
  assign w_int_tick  = (r_cnt == CNT_LAST);
  assign w_expire    = (r_wd == WD_LAST) && !w_ext_edge;
  assign w_src_ext   = (r_state == ST_LOCK) && (r_mode_q == MODE_SCAN);

  // The divider clears on the same edge that raises restart, so it reads 0 during the restart cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q  <= MODE_SCAN;
      r_restart <= 1'b0;
      r_step    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_mode_q  <= w_mode_d;
      r_restart <= w_restart_d;
      r_step    <= w_restart_d ? 1'b0 : (w_src_ext ? w_ext_edge : w_int_tick);
      if (w_restart_d || w_int_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_wd <= '0;
    else if (w_ext_edge)
      r_wd <= '0;
    else if (r_wd != WD_MAX)
      r_wd <= r_wd + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SEEK;
      r_ecnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ecnt  <= w_ecnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ecnt_d  = r_ecnt;
    case (r_state)
      ST_SEEK: begin
        if (r_ecnt == EC_TARGET) begin
          w_state_d = ST_LOCK;
          w_ecnt_d  = '0;
        end else if (w_expire) begin
          w_ecnt_d = '0;
        end else if (w_ext_edge) begin
          w_ecnt_d = r_ecnt + EC_W'(1);
        end
      end
      ST_LOCK: begin
        w_ecnt_d = '0;
        if (w_expire)
          w_state_d = ST_SEEK;
      end
      default: begin
        w_state_d = ST_SEEK;
        w_ecnt_d  = '0;
      end
    endcase
  end

  assign step_en    = r_step;
  assign mode       = r_mode_q;
  assign restart    = r_restart;
  assign src_ext    = w_src_ext;
  assign timer_lost = (r_state == ST_SEEK);

endmodule

// File: tb/tb_flash_tick_scheduler.sv
// Self-checking bench: event-time model checked every cycle plus directed literal checks.
module tb_flash_tick_scheduler;

  localparam int P  = 10;
  localparam int WD = 40;
  localparam int RE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_timer = 1'b0;
  logic [7:0] control = 8'd0;
  logic       step_en;
  logic [1:0] mode;
  logic       restart;
  logic       src_ext;
  logic       timer_lost;

  flash_tick_scheduler #(
    .INT_PERIOD    (P),
    .WD_LIMIT      (WD),
    .RECOVER_EDGES (RE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_timer    (i_timer),
    .control    (control),
    .step_en    (step_en),
    .mode       (mode),
    .restart    (restart),
    .src_ext    (src_ext),
    .timer_lost (timer_lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_mode(input logic [7:0] c);
    if (c == 8'd0) return 0;
    if ($countones(c) == 1) return 1;
    return 2;
  endfunction

  // Model: times measured in cycles since reset; watchdog = cycles since the last edge,
  // divider phase = cycles since the last restart, edges = 3-cycle-delayed pin rises.
  int m_cyc, m_anchor, m_origin, m_seen, m_mode;
  bit m_locked, m_ext, m_restart, m_step;
  bit m_pins[$];

  task automatic model_edge();
    bit tick_o, expire_o, src_o, rs;
    int wd_o, nm;
    if (rst) begin
      m_cyc = 0; m_anchor = 0; m_origin = 0; m_seen = 0; m_mode = 0;
      m_locked = 0; m_ext = 0; m_restart = 0; m_step = 0;
      m_pins = '{0, 0, 0, 0};
    end else begin
      tick_o   = ((m_cyc - m_origin) % P) == P - 1;
      wd_o     = m_cyc - m_anchor;
      if (wd_o > WD) wd_o = WD;
      expire_o = (wd_o == WD - 1) && !m_ext;
      src_o    = m_locked && (m_mode == 0);
      nm       = exp_mode(control);
      rs       = (nm != m_mode);
      m_cyc++;
      if (m_ext) m_anchor = m_cyc;
      if (rs) m_origin = m_cyc;
      if (!m_locked) begin
        if (m_seen == RE) begin m_locked = 1; m_seen = 0; end
        else if (expire_o) m_seen = 0;
        else if (m_ext) m_seen++;
      end else if (expire_o) begin
        m_locked = 0;
      end
      m_step = rs ? 1'b0 : (src_o ? m_ext : tick_o);
      m_pins.push_front(i_timer);
      void'(m_pins.pop_back());
      m_ext = m_pins[2] && !m_pins[3];
      m_mode = nm;
      m_restart = rs;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("step_en",    step_en,    m_step);
      check("restart",    restart,    m_restart);
      check("mode",       mode,       m_mode);
      check("src_ext",    src_ext,    m_locked && (m_mode == 0));
      check("timer_lost", timer_lost, !m_locked);
    end
  end

  task automatic pin_periods(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      i_timer = 1'b1;
      repeat (period / 2) @(negedge clk);
      i_timer = 1'b0;
      repeat (period - period / 2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  int steps, rsts, t_step, t_lost, lat;

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    check("rst_step_en", step_en, 0);
    check("rst_restart", restart, 0);
    check("rst_mode", mode, 0);
    check("rst_src_ext", src_ext, 0);
    check("rst_timer_lost", timer_lost, 1);
    rst = 1'b0;

    // 1: internal divider only
    steps = 0; rsts = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step_en) steps++;
      if (restart) rsts++;
    end
    check("t1_steps_in_50", steps, 5);
    check("t1_restarts", rsts, 0);
    check("t1_timer_lost", timer_lost, 1);

    // 2: acquire the 555 at period 20, then measure pin-to-step latency
    pin_periods(3, 20);
    check("t2_timer_lost", timer_lost, 0);
    check("t2_src_ext", src_ext, 1);
    i_timer = 1'b1; lat = 0; steps = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) i_timer = 1'b0;
      if (step_en) begin steps++; if (lat == 0) lat = i; end
    end
    check("t2_latency", lat, 4);
    check("t2_steps_per_period", steps, 1);

    // 5: edges spaced exactly WD_LIMIT apart land on wd==39 and keep the lock
    for (int k = 0; k < 4; k++) begin
      pin_periods(1, 40);
      check("t5_still_locked", timer_lost, 0);
    end

    // 3: last rise, then silence: loss exactly 40 clk after the step it produced
    i_timer = 1'b1; t_step = 0; t_lost = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 20) i_timer = 1'b0;
      if (step_en && t_step == 0) t_step = i;
      if (timer_lost && t_lost == 0) t_lost = i;
    end
    check("t3_step_time", t_step, 4);
    check("t3_loss_delay", t_lost - t_step, 40);
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step_en) steps++;
    end
    check("t3_int_steps_in_10", steps, 1);

    // 4: mode changes and restart
    control = 8'b0001_0000;
    @(negedge clk);
    check("t4_mode_track", mode, 1);
    check("t4_restart", restart, 1);
    check("t4_step_blocked", step_en, 0);
    t_step = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) check("t4_restart_width", restart, 0);
      if (step_en && t_step == 0) t_step = i;
    end
    check("t4_first_step", t_step, 10);
    check("t4_src_ext", src_ext, 0);
    control = 8'b0001_0010;
    @(negedge clk);
    check("t4_mode_blink", mode, 2);
    check("t4_restart2", restart, 1);
    repeat (5) @(negedge clk);

    // 6: reset while locked, mid-period with an edge in flight
    control = 8'd0;
    pin_periods(4, 20);
    check("t6_locked", timer_lost, 0);
    i_timer = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; i_timer = 1'b0;
    @(negedge clk);
    check("t6_rst_step_en", step_en, 0);
    check("t6_rst_restart", restart, 0);
    check("t6_rst_mode", mode, 0);
    check("t6_rst_src_ext", src_ext, 0);
    check("t6_rst_timer_lost", timer_lost, 1);
    rst = 1'b0;
    pin_periods(2, 20);
    check("t6_two_edges_not_locked", timer_lost, 1);
    pin_periods(1, 20);
    check("t6_third_edge_locked", timer_lost, 0);
    check("t6_src_ext", src_ext, 1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
